reg_file_sb: RTL and testbench

Parametrised register file with integrated one-hot write decode, two combinational read ports, write-to-read bypass and a per-register busy scoreboard. Sits in the decode stage of the pipeline: reads operands, accepts writeback from the last stage, and raises `stall` when an issuing instruction depends on a result that has not yet been written back. Replaces the fixed 16-entry decode/register arrangement and supports any register count and data width.

---
 rtl/rf_pkg.sv | 6 +
 rtl/wr_decoder.sv | 23 ++
 rtl/reg_file_sb.sv | 108 ++++++++++
 tb/tb_reg_file_sb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the decode-stage register file and its write decoder.
package rf_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 16;
    localparam int ZERO_IDX     = 0;
endpackage

// File: rtl/wr_decoder.sv
// Enable + address to one-hot wordline; bit ZERO_IDX is masked when ZERO_REG is set.
module wr_decoder
    import rf_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                   en,
    input  logic [ADDR_W-1:0]      addr,
    output logic [(1<<ADDR_W)-1:0] wordLine
);

    always_comb begin
        wordLine = '0;
        if (en) begin
            wordLine[addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            wordLine[ZERO_IDX] = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file: storage, two bypassed read ports, busy scoreboard and issue stall.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic [ADDR_W-1:0]   iss_src_a,
    input  logic [ADDR_W-1:0]   iss_src_b,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy
);

    typedef logic [NUM_REGS-1:0][DATA_W-1:0] regArr_t;

    regArr_t             regs;
    logic [NUM_REGS-1:0] wrLine;
    logic [NUM_REGS-1:0] setLine;
    logic [NUM_REGS-1:0] clrLine;
    logic [NUM_REGS-1:0] liveMask;
    logic [NUM_REGS-1:0] effBusy;
    logic [NUM_REGS-1:0] busyNext;
    logic                stallInt;

    // The wordline already excludes the zero register, so it doubles as the bypass-hit vector.
    function automatic logic [DATA_W-1:0] readPort(
        input logic [ADDR_W-1:0]   a,
        input regArr_t             r,
        input logic [NUM_REGS-1:0] w,
        input logic [DATA_W-1:0]   d
    );
        logic [DATA_W-1:0] v;
        v = r[a];
        if (ZERO_REG != 0 && a == ADDR_W'(ZERO_IDX)) begin
            v = '0;
        end
        if (BYPASS != 0 && w[a]) begin
            v = d;
        end
        return v;
    endfunction

    wr_decoder #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) uWrDec (
        .en       (wr_en),
        .addr     (wr_addr),
        .wordLine (wrLine)
    );

    wr_decoder #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) uIssDec (
        .en       (iss_en & ~stallInt),
        .addr     (iss_dst),
        .wordLine (setLine)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wrLine[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        rd_data_a = readPort(rd_addr_a, regs, wrLine, wr_data);
        rd_data_b = readPort(rd_addr_b, regs, wrLine, wr_data);
    end

    always_comb begin
        liveMask = '1;
        if (ZERO_REG != 0) begin
            liveMask[ZERO_IDX] = 1'b0;
        end
        clrLine  = (BYPASS != 0) ? wrLine : '0;
        effBusy  = busy & ~clrLine & liveMask;
        stallInt = iss_en & (effBusy[iss_src_a] | effBusy[iss_src_b] | effBusy[iss_dst]);
        // Set after clear: a same-cycle new producer keeps the register busy.
        busyNext = ((busy & ~wrLine) | setLine) & liveMask;
    end

    assign stall = stallInt;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 instance share every input.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic        iss_en;
    logic [3:0]  iss_dst, iss_src_a, iss_src_b;

    logic [15:0] rdA1, rdB1, rdA0, rdB0;
    logic        stall1, stall0;
    logic [15:0] busy1, busy0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rdA1), .rd_data_b(rdB1),
        .iss_en(iss_en), .iss_dst(iss_dst), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
        .stall(stall1), .busy(busy1)
    );

    reg_file_sb #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(1), .BYPASS(0)) dutNb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rdA0), .rd_data_b(rdB0),
        .iss_en(iss_en), .iss_dst(iss_dst), .iss_src_a(iss_src_a), .iss_src_b(iss_src_b),
        .stall(stall0), .busy(busy0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        iss_en = 0; iss_dst = 0; iss_src_a = 0; iss_src_b = 0;
    endtask

    initial begin
        rst = 1; rd_addr_a = 0; rd_addr_b = 0;
        idle();
        tick();
        rst = 0;
        #1;
        chk("reset busy", 32'(busy1), 32'h0);
        chk("reset busy nb", 32'(busy0), 32'h0);
        iss_en = 1; iss_dst = 9; iss_src_a = 4; iss_src_b = 11;
        #1;
        chk("reset stall", 32'(stall1), 32'h0);
        iss_en = 0;
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i);
            #1;
            chk("reset rd a", 32'(rdA1), 32'h0);
            chk("reset rd b", 32'(rdB1), 32'h0);
        end

        // Write r5 with same-cycle read.
        wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF; rd_addr_a = 5; rd_addr_b = 6;
        #1;
        chk("bypass r5 same cycle", 32'(rdA1), 32'hBEEF);
        chk("nobypass r5 same cycle", 32'(rdA0), 32'h0);
        chk("bypass r6 untouched", 32'(rdB1), 32'h0);
        tick();
        idle();
        #1;
        chk("r5 after edge", 32'(rdA1), 32'hBEEF);
        chk("nobypass r5 after edge", 32'(rdA0), 32'hBEEF);

        // Zero register: not writable, not claimable.
        wr_en = 1; wr_addr = 0; wr_data = 16'h1234; rd_addr_a = 0;
        iss_en = 1; iss_dst = 0;
        #1;
        chk("r0 bypass suppressed", 32'(rdA1), 32'h0);
        chk("r0 issue no stall", 32'(stall1), 32'h0);
        tick();
        idle();
        #1;
        chk("r0 still zero", 32'(rdA1), 32'h0);
        chk("r0 not busy", 32'(busy1), 32'h0);

        // RAW hazard on r3.
        iss_en = 1; iss_dst = 3;
        #1;
        chk("issue r3 no stall", 32'(stall1), 32'h0);
        tick();
        chk("busy r3 set", 32'(busy1), 32'h0008);
        iss_en = 1; iss_dst = 1; iss_src_a = 3; iss_src_b = 0;
        #1;
        chk("raw stall", 32'(stall1), 32'h1);
        tick();
        chk("stalled issue no effect", 32'(busy1), 32'h0008);
        chk("raw stall holds", 32'(stall1), 32'h1);
        wr_en = 1; wr_addr = 3; wr_data = 16'h5A5A; rd_addr_a = 3;
        #1;
        chk("writeback clears stall", 32'(stall1), 32'h0);
        chk("writeback bypass data", 32'(rdA1), 32'h5A5A);
        chk("nobypass still stalls", 32'(stall0), 32'h1);
        tick();
        idle();
        #1;
        chk("busy after wb+issue", 32'(busy1), 32'h0002);
        chk("busy nb after wb", 32'(busy0), 32'h0000);
        chk("r3 stored", 32'(rdA0), 32'h5A5A);

        // Same-cycle writeback and new claim of r7: set wins.
        wr_en = 1; wr_addr = 7; wr_data = 16'h7777;
        iss_en = 1; iss_dst = 7;
        #1;
        chk("r7 claim no stall", 32'(stall1), 32'h0);
        tick();
        idle(); rd_addr_a = 7;
        #1;
        chk("busy r7 set wins", 32'(busy1), 32'h0082);
        chk("busy nb r7 set wins", 32'(busy0), 32'h0080);
        chk("r7 holds data", 32'(rdA1), 32'h7777);

        // Reset mid-stall.
        rst = 1; tick(); rst = 0;
        for (int i = 4; i < 8; i++) begin
            iss_en = 1; iss_dst = 4'(i);
            tick();
        end
        idle();
        chk("busy 0xF0", 32'(busy1), 32'h00F0);
        iss_en = 1; iss_dst = 2; iss_src_b = 6;
        #1;
        chk("stall via src_b", 32'(stall1), 32'h1);
        iss_src_b = 0; iss_dst = 7;
        #1;
        chk("stall via dst", 32'(stall1), 32'h1);
        iss_en = 0;
        #1;
        chk("no issue no stall", 32'(stall1), 32'h0);
        iss_en = 1; iss_dst = 2; iss_src_a = 5;
        #1;
        chk("stall before reset", 32'(stall1), 32'h1);
        wr_en = 1; wr_addr = 9; wr_data = 16'hAAAA;
        rst = 1;
        tick();
        rst = 0; wr_en = 0;
        #1;
        chk("busy after reset", 32'(busy1), 32'h0);
        chk("busy nb after reset", 32'(busy0), 32'h0);
        chk("stall after reset", 32'(stall1), 32'h0);
        iss_en = 0;
        rd_addr_a = 5; rd_addr_b = 7;
        #1;
        chk("r5 cleared", 32'(rdA1), 32'h0);
        chk("r7 cleared", 32'(rdB1), 32'h0);
        rd_addr_a = 3; rd_addr_b = 9;
        #1;
        chk("r3 cleared", 32'(rdA0), 32'h0);
        chk("write ignored in reset", 32'(rdB0), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
